// File: rtl/fifo_wr_arbiter_if.sv
// Writer-port and shared-FIFO signals of the FIFO write arbiter.
// The master modport is the arbiter side and the slave modport is the environment side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_wen;
    logic [WIDTH-1:0]      fifo_din;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wen, fifo_din, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wen, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that grants one writer port at a time a burst of up to BURST words
// into a shared FIFO. Arbitration takes one IDLE bubble cycle per grant.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   owner_q, owner_d;
    logic [GW-1:0]   last_q, last_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic [GW-1:0]   next_owner;
    logic            any_req;
    logic            found;
    int              idx;
    logic            owner_valid;
    logic            xfer;
    logic            last_beat;
    logic [WIDTH-1:0] owner_data;

    assign any_req     = |bus.req_valid;
    assign owner_valid = bus.req_valid[owner_q];
    assign owner_data  = bus.req_data[int'(owner_q)*WIDTH +: WIDTH];
    assign last_beat   = (beat_cnt_q == 8'(BURST - 1));
    // A word moves only in OWN, with the owner valid, FIFO not full and no reset in progress.
    assign xfer        = !rst && (state_q == OWN) && owner_valid && !bus.fifo_full;

    // Search starts just past the previous owner, so a released port has lowest priority.
    always_comb begin
        next_owner = last_q;
        found      = 1'b0;
        idx        = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                next_owner = GW'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        owner_q    <= owner_d;
        last_q     <= last_d;
        beat_cnt_q <= beat_cnt_d;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        if (rst) begin
            state_d    = IDLE;
            owner_d    = '0;
            last_d     = GW'(NREQ - 1);
            beat_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d    = OWN;
                        owner_d    = next_owner;
                        beat_cnt_d = '0;
                    end
                end
                OWN: begin
                    if (!owner_valid) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else if (xfer) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        if (last_beat) begin
                            state_d = IDLE;
                            last_d  = owner_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are forced quiet during reset so an aborted burst writes nothing.
    always_comb begin
        bus.req_ready = '0;
        bus.fifo_wen  = 1'b0;
        bus.fifo_din  = '0;
        bus.grant_id  = '0;
        bus.busy      = 1'b0;
        if (!rst && (state_q == OWN)) begin
            bus.req_ready[owner_q] = !bus.fifo_full;
            bus.fifo_wen           = xfer;
            bus.fifo_din           = owner_data;
            bus.grant_id           = owner_q;
            bus.busy               = 1'b1;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of writer ports; legal range 2..8.
REQ-002 Parameter WIDTH, default 32: data word width; equals the write-data width of the shared FIFO.
REQ-003 Parameter BURST, default 4: maximum number of accepted words per grant; legal range 1..256.
REQ-004 Reset rst is synchronous and active-high; clock is clk.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  NREQ  per-port write request; bit i belongs to port i.
REQ-008 req_data  input  NREQ*WIDTH  per-port data; port i uses bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  NREQ  per-port accept; one-hot or zero.
REQ-010 fifo_full  input  1  full flag from the shared FIFO.
REQ-011 fifo_wen  output  1  write enable to the shared FIFO.
REQ-012 fifo_din  output  WIDTH  write data to the shared FIFO.
REQ-013 grant_id  output  max(1,clog2(NREQ))  index of the current owner; 0 when idle.
REQ-014 busy  output  1  high while in state OWN.

Function
REQ-015 The FSM has two states: IDLE and OWN; state, owner, last, and beat_cnt are registered.
REQ-016 In IDLE with any req_valid bit set, the next owner is the first set bit searching from (last+1) mod NREQ upward, with wrap-around; the FSM moves to OWN on the next edge.
REQ-017 In IDLE: req_ready=0, fifo_wen=0, and no word is transferred; arbitration therefore costs one bubble cycle.
REQ-018 In OWN: req_ready[owner] = !fifo_full (combinational), and all other req_ready bits are 0.
REQ-019 In OWN: fifo_wen = req_valid[owner] && !fifo_full, and fifo_din = req_data slice of owner (combinational).
REQ-020 A transfer is a cycle with req_valid[owner] && req_ready[owner]; exactly one word is written per transfer.
REQ-021 beat_cnt (8 bits) clears on entry to OWN and increments on each transfer.
REQ-022 The grant is released (OWN->IDLE, last<=owner) in the cycle of the transfer where beat_cnt == BURST-1.
REQ-023 The grant is also released in any OWN cycle where req_valid[owner] == 0, whether or not fifo_full is set.
REQ-024 While fifo_full=1 and req_valid[owner]=1, the owner holds the grant, and neither beat_cnt nor the FIFO changes.
REQ-025 The arbiter never asserts fifo_wen while fifo_full=1; no word is dropped or duplicated.
REQ-026 Requests from non-owners are ignored until release; a port re-requesting after its release has lowest priority in the next arbitration.
REQ-027 With BURST=1, every accepted word is followed by an IDLE arbitration cycle.

Reset
REQ-028 On rst: state=IDLE, beat_cnt=0, owner=0, and last=NREQ-1, so port 0 has first priority.
REQ-029 During and after rst, until the next arbitration: req_ready=0, fifo_wen=0, fifo_din=0, grant_id=0, busy=0.
REQ-030 rst asserted mid-burst aborts the grant with no write in that cycle; the words already written remain in the FIFO.

Verification
REQ-031 Reset, then req_valid=4'b0001 held with 6 distinct words and fifo_full=0 -> cycle 1 IDLE; cycles 2-5 write words 0-3; cycle 6 IDLE; cycles 7-8 write words 4-5.
REQ-032 All four ports valid continuously, BURST=4 -> grant order 0,1,2,3,0; each grant writes 4 words; 1 bubble between grants; 16 words in 20 cycles.
REQ-033 Port 2 owner with fifo_full forced high for 3 cycles mid-burst -> fifo_wen=0 and req_ready=0 for 3 cycles, grant held, beat_cnt frozen; the burst completes with exactly 4 words total.
REQ-034 Port 1 owner drops req_valid after 2 words while port 3 is valid -> release, last=1, next owner 3; port 1 re-requests and waits behind 2,3,0 if valid.
REQ-035 rst pulsed while port 0 is at beat 2 -> no write in the reset cycle, busy=0, and the next grant goes to the lowest valid index starting at 0.
REQ-036 Scoreboard over random valid/full stimulus for 10k cycles -> the FIFO write sequence equals the interleaving of per-port streams; no loss, no duplication, and no fifo_wen while full.
